// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of independent down/up counters with auto-reload and cascade chain
//
// Purpose: COUNTER_COUNT counters of WIDTH bits, one explicit operation per cycle
//          on the counter addressed by sel, plus a combinational cascade that lets
//          a reload in counter k-1 step counter k (nested loop counters).
// Ports:
//   clock       in   clock, all state updates on posedge
//   rst_n       in   synchronous active-low reset
//   opcode      in   3-bit operation for this cycle
//   sel         in   target counter index for per-counter ops
//   const_data  in   reload constants, counter k uses [k*WIDTH +: WIDTH]
//   data_in     in   external load value, zero-extended
//   cascade_en  in   bit k chains counter k to counter k-1 (bit 0 ignored)
//   zero        out  zero[k] = (counter k == 0), combinational from registers
//   wrap        out  registered one-cycle pulse after counter k reloads
module counter_bank #(
  parameter int COUNTER_COUNT = 4,
  parameter int WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  localparam int SEL_WIDTH = $clog2(COUNTER_COUNT)
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic [2:0]                     opcode,
  input  logic [SEL_WIDTH-1:0]           sel,
  input  logic [COUNTER_COUNT*WIDTH-1:0] const_data,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [COUNTER_COUNT-1:0]       cascade_en,
  output logic [COUNTER_COUNT-1:0]       zero,
  output logic [COUNTER_COUNT-1:0]       wrap
);

  localparam logic [2:0] OP_NOP        = 3'b000;
  localparam logic [2:0] OP_LOAD_CONST = 3'b001;
  localparam logic [2:0] OP_DEC        = 3'b010;
  localparam logic [2:0] OP_LOAD_DATA  = 3'b011;
  localparam logic [2:0] OP_CLEAR_ALL  = 3'b100;
  localparam logic [2:0] OP_CLEAR      = 3'b101;
  localparam logic [2:0] OP_DEC_RELOAD = 3'b110;
  localparam logic [2:0] OP_INC        = 3'b111;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [WIDTH-1:0]         cnt [COUNTER_COUNT];
  logic [WIDTH-1:0]         nxt [COUNTER_COUNT];
  logic [COUNTER_COUNT-1:0] ev;
  logic                     sel_valid;
  logic                     ev_chain;
  logic                     step;

  // Out-of-range sel (non-power-of-2 counts) turns per-counter ops into NOPs.
  assign sel_valid = int'(sel) < COUNTER_COUNT;

  always_comb begin
    ev       = '0;
    ev_chain = 1'b0;
    step     = 1'b0;
    for (int k = 0; k < COUNTER_COUNT; k++) begin
      nxt[k] = cnt[k];
    end
    // Walk upward so ev[k-1] is already resolved when counter k is decided;
    // ev_chain is 0 entering counter 0, so cascade_en[0] has no effect.
    for (int k = 0; k < COUNTER_COUNT; k++) begin
      step = cascade_en[k] & ev_chain;
      if (opcode == OP_CLEAR_ALL) begin
        nxt[k] = '0;
      end else if (sel_valid && int'(sel) == k) begin
        case (opcode)
          OP_NOP:        nxt[k] = cnt[k];
          OP_LOAD_CONST: nxt[k] = const_data[k*WIDTH +: WIDTH];
          OP_DEC:        nxt[k] = cnt[k] - ONE;
          OP_LOAD_DATA:  nxt[k] = WIDTH'(data_in);
          OP_CLEAR:      nxt[k] = '0;
          OP_DEC_RELOAD: begin
            if (cnt[k] == '0) begin
              nxt[k] = const_data[k*WIDTH +: WIDTH];
              ev[k]  = 1'b1;
            end else begin
              nxt[k] = cnt[k] - ONE;
            end
          end
          OP_INC:        nxt[k] = (cnt[k] == ALL1) ? ALL1 : cnt[k] + ONE;
          default:       nxt[k] = cnt[k];
        endcase
      end else if (step) begin
        // A stepped counter behaves exactly like DEC_RELOAD.
        if (cnt[k] == '0) begin
          nxt[k] = const_data[k*WIDTH +: WIDTH];
          ev[k]  = 1'b1;
        end else begin
          nxt[k] = cnt[k] - ONE;
        end
      end
      ev_chain = ev[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int k = 0; k < COUNTER_COUNT; k++) begin
        cnt[k] <= '0;
      end
      wrap <= '0;
    end else begin
      for (int k = 0; k < COUNTER_COUNT; k++) begin
        cnt[k] <= nxt[k];
      end
      wrap <= ev;
    end
  end

  always_comb begin
    zero = '0;
    for (int k = 0; k < COUNTER_COUNT; k++) begin
      zero[k] = (cnt[k] == '0);
    end
  end

endmodule
